// File: rtl/excp_commit_ctrl.sv
// Exception/interrupt commit scheduler for the dual-issue pipeline.
// Picks the winning exception of the two commit slots (plus a pending interrupt),
// strobes it into CP0 for one cycle, flushes the pipeline and then offers the new
// fetch PC with a valid/ready handshake.
module excp_commit_ctrl #(
    parameter logic [31:0] EXC_OFFSET = 32'h0000_0180,
    parameter logic [4:0]  ERET_CODE  = 5'h0e
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        slot1_valid_i,
    input  logic        slot2_valid_i,
    input  logic [8:0]  slot1_excp_i,
    input  logic [8:0]  slot2_excp_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [2:0]  cp0_wsel_i,
    input  logic [31:0] cp0_wdata_i,
    output logic        excp_flag_o,
    output logic [4:0]  excp_type_o,
    output logic        excp_first_inst_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic        busy_o
);

    typedef enum logic {StIdle, StRedirect} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic        int_pend;
    logic        irq1, irq2;
    logic [6:0]  dec1, dec2, win;
    logic        win_first;
    logic        epc_fwd;
    logic [31:0] target;
    logic        commit;

    // Status/Cause bits outside IE/EXL/IM/IP are not used here.
    logic unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    // Per-slot priority decode; result is {req, is_eret, exc_code}.
    function automatic logic [6:0] decode(input logic irq, input logic [8:0] e);
        if (irq)       return {2'b10, 5'h00};
        else if (e[0]) return {2'b10, 5'h04};  // fetch_adel
        else if (e[1]) return {2'b10, 5'h0a};  // ri
        else if (e[2]) return {2'b10, 5'h0c};  // ov
        else if (e[3]) return {2'b10, 5'h0d};  // tr
        else if (e[4]) return {2'b10, 5'h08};  // sys
        else if (e[5]) return {2'b10, 5'h09};  // bp
        else if (e[6]) return {2'b10, 5'h04};  // mem_adel
        else if (e[7]) return {2'b10, 5'h05};  // mem_ades
        else if (e[8]) return {2'b11, ERET_CODE};
        else           return 7'b0;
    endfunction

    // Request arbitration: the interrupt rides on the oldest valid slot, and a
    // requesting valid slot 1 always beats slot 2.
    always_comb begin
        int_pend  = (|(cause_i[15:8] & status_i[15:8])) & status_i[0] & ~status_i[1];
        irq1      = int_pend & slot1_valid_i;
        irq2      = int_pend & ~slot1_valid_i & slot2_valid_i;
        dec1      = decode(irq1, slot1_excp_i & {9{slot1_valid_i}});
        dec2      = decode(irq2, slot2_excp_i & {9{slot2_valid_i}});
        win_first = dec1[6];
        win       = win_first ? dec1 : dec2;
        // MTC0 to EPC in the ERET commit cycle must win over the stale register value.
        epc_fwd   = cp0_we_i && (cp0_waddr_i == 5'd14) && (cp0_wsel_i == 3'd0);
        if (win[5]) target = epc_fwd ? cp0_wdata_i : epc_i;
        else        target = ebase_i + EXC_OFFSET;
        commit    = (state_q == StIdle) && !stall_i && !rst && win[6];
    end

    // Next-state and output decode.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        excp_flag_o       = 1'b0;
        excp_type_o       = 5'h00;
        excp_first_inst_o = 1'b0;
        flush_o           = 1'b0;
        redirect_valid_o  = 1'b0;
        busy_o            = 1'b0;
        case (state_q)
            StIdle: begin
                if (commit) begin
                    excp_flag_o       = 1'b1;
                    excp_type_o       = win[4:0];
                    excp_first_inst_o = win_first;
                    flush_o           = 1'b1;
                    pc_d              = target;
                    state_d           = StRedirect;
                end
            end
            StRedirect: begin
                redirect_valid_o = 1'b1;
                flush_o          = 1'b1;
                busy_o           = 1'b1;
                if (redirect_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign redirect_pc_o = pc_q;

    // State and redirect target registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Directed testbench for excp_commit_ctrl.
module tb_excp_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        slot1_valid_i, slot2_valid_i;
    logic [8:0]  slot1_excp_i, slot2_excp_i;
    logic [31:0] status_i, cause_i, epc_i, ebase_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [2:0]  cp0_wsel_i;
    logic [31:0] cp0_wdata_i;
    logic        excp_flag_o;
    logic [4:0]  excp_type_o;
    logic        excp_first_inst_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    excp_commit_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .slot1_valid_i     (slot1_valid_i),
        .slot2_valid_i     (slot2_valid_i),
        .slot1_excp_i      (slot1_excp_i),
        .slot2_excp_i      (slot2_excp_i),
        .status_i          (status_i),
        .cause_i           (cause_i),
        .epc_i             (epc_i),
        .ebase_i           (ebase_i),
        .cp0_we_i          (cp0_we_i),
        .cp0_waddr_i       (cp0_waddr_i),
        .cp0_wsel_i        (cp0_wsel_i),
        .cp0_wdata_i       (cp0_wdata_i),
        .excp_flag_o       (excp_flag_o),
        .excp_type_o       (excp_type_o),
        .excp_first_inst_o (excp_first_inst_o),
        .flush_o           (flush_o),
        .redirect_valid_o  (redirect_valid_o),
        .redirect_pc_o     (redirect_pc_o),
        .redirect_ready_i  (redirect_ready_i),
        .busy_o            (busy_o)
    );

    task automatic clear_inputs();
        stall_i = 0; slot1_valid_i = 0; slot2_valid_i = 0;
        slot1_excp_i = 0; slot2_excp_i = 0;
        status_i = 0; cause_i = 0; epc_i = 0; ebase_i = 0;
        cp0_we_i = 0; cp0_waddr_i = 0; cp0_wsel_i = 0; cp0_wdata_i = 0;
        redirect_ready_i = 0;
    endtask

    // Called one step after the edge that entered REDIRECT; completes the handshake.
    task automatic finish_redirect(input string tag);
        redirect_ready_i = 1;
        @(posedge clk); #1;
        n_checks++;
        if (redirect_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: valid=%0b busy=%0b want 0 0", tag, redirect_valid_o, busy_o);
        end
        redirect_ready_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({excp_flag_o, excp_type_o, excp_first_inst_o, flush_o, redirect_valid_o, busy_o} !== 10'b0
            || redirect_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: flag=%0b type=%h flush=%0b valid=%0b busy=%0b pc=%h want all 0",
                     excp_flag_o, excp_type_o, flush_o, redirect_valid_o, busy_o, redirect_pc_o);
        end
        rst = 0;
    endtask

    task automatic test_ri_slot1();
        @(negedge clk);
        slot1_valid_i = 1; slot1_excp_i = 9'h002;
        slot2_valid_i = 1; slot2_excp_i = 9'h010;
        ebase_i = 32'hBFC0_0200;
        #1;
        n_checks++;
        if (excp_flag_o !== 1 || excp_type_o !== 5'h0a || excp_first_inst_o !== 1 || flush_o !== 1
            || redirect_valid_o !== 0) begin
            n_fail++;
            $display("FAIL ri_commit: flag=%0b type=%h first=%0b flush=%0b valid=%0b want 1 0a 1 1 0",
                     excp_flag_o, excp_type_o, excp_first_inst_o, flush_o, redirect_valid_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (excp_flag_o !== 0 || redirect_valid_o !== 1 || redirect_pc_o !== 32'hBFC0_0380
            || busy_o !== 1 || flush_o !== 1) begin
            n_fail++;
            $display("FAIL ri_redirect: flag=%0b valid=%0b pc=%h busy=%0b want 0 1 bfc00380 1",
                     excp_flag_o, redirect_valid_o, redirect_pc_o, busy_o);
        end
        clear_inputs();
        finish_redirect("ri");
    endtask

    // Combinational-only checks: inputs are removed before the edge so nothing commits.
    task automatic test_priority();
        @(negedge clk);
        slot1_valid_i = 1; slot1_excp_i = 9'b1_0001_1000;   // eret|sys|tr
        #1;
        n_checks++;
        if (excp_flag_o !== 1 || excp_type_o !== 5'h0d || excp_first_inst_o !== 1) begin
            n_fail++;
            $display("FAIL prio_tr: flag=%0b type=%h first=%0b want 1 0d 1",
                     excp_flag_o, excp_type_o, excp_first_inst_o);
        end
        slot1_excp_i = 9'b0_0100_0000;                      // mem_adel
        #1;
        n_checks++;
        if (excp_type_o !== 5'h04) begin
            n_fail++;
            $display("FAIL prio_madel: type=%h want 04", excp_type_o);
        end
        slot1_excp_i = 0; slot2_valid_i = 1; slot2_excp_i = 9'b0_1010_0000;  // mem_ades|bp
        #1;
        n_checks++;
        if (excp_flag_o !== 1 || excp_type_o !== 5'h09 || excp_first_inst_o !== 0) begin
            n_fail++;
            $display("FAIL slot2_bp: flag=%0b type=%h first=%0b want 1 09 0",
                     excp_flag_o, excp_type_o, excp_first_inst_o);
        end
        slot1_valid_i = 0; slot1_excp_i = 9'h002; slot2_excp_i = 0; redirect_ready_i = 1;
        #1;
        n_checks++;
        if (excp_flag_o !== 0 || flush_o !== 0 || redirect_valid_o !== 0) begin
            n_fail++;
            $display("FAIL invalid_slot: flag=%0b flush=%0b valid=%0b want 0 0 0",
                     excp_flag_o, flush_o, redirect_valid_o);
        end
        clear_inputs();
        @(posedge clk); #1;
        n_checks++;
        if (busy_o !== 0) begin
            n_fail++;
            $display("FAIL prio_nocommit: busy=%0b want 0", busy_o);
        end
    endtask

    task automatic test_interrupt();
        @(negedge clk);
        status_i = 32'h0000_8001; cause_i = 32'h0000_8000;
        #1;
        n_checks++;
        if (excp_flag_o !== 0) begin
            n_fail++;
            $display("FAIL int_noslot: flag=%0b want 0", excp_flag_o);
        end
        status_i = 32'h0000_8003; slot2_valid_i = 1;
        #1;
        n_checks++;
        if (excp_flag_o !== 0) begin
            n_fail++;
            $display("FAIL int_exl: flag=%0b want 0", excp_flag_o);
        end
        status_i = 32'h0000_8001; ebase_i = 32'h8000_0000;
        #1;
        n_checks++;
        if (excp_flag_o !== 1 || excp_type_o !== 5'h00 || excp_first_inst_o !== 0) begin
            n_fail++;
            $display("FAIL int_slot2: flag=%0b type=%h first=%0b want 1 00 0",
                     excp_flag_o, excp_type_o, excp_first_inst_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (redirect_pc_o !== 32'h8000_0180) begin
            n_fail++;
            $display("FAIL int_pc: pc=%h want 80000180", redirect_pc_o);
        end
        clear_inputs();
        finish_redirect("int");
    endtask

    task automatic test_eret();
        @(negedge clk);
        slot1_valid_i = 1; slot1_excp_i = 9'h100; epc_i = 32'h0;
        cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wsel_i = 3'd0; cp0_wdata_i = 32'h8000_1000;
        #1;
        n_checks++;
        if (excp_flag_o !== 1 || excp_type_o !== 5'h0e || excp_first_inst_o !== 1) begin
            n_fail++;
            $display("FAIL eret_type: flag=%0b type=%h first=%0b want 1 0e 1",
                     excp_flag_o, excp_type_o, excp_first_inst_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (redirect_pc_o !== 32'h8000_1000) begin
            n_fail++;
            $display("FAIL eret_fwd_pc: pc=%h want 80001000", redirect_pc_o);
        end
        finish_redirect("eret_fwd");
        // Write to a different select must not be forwarded.
        @(negedge clk);
        epc_i = 32'h0000_1234; cp0_wsel_i = 3'd1; cp0_wdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        n_checks++;
        if (redirect_pc_o !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL eret_epc_pc: pc=%h want 00001234", redirect_pc_o);
        end
        clear_inputs();
        finish_redirect("eret_epc");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        slot1_valid_i = 1; slot1_excp_i = 9'h001; ebase_i = 32'hFFFF_FF00;
        #1;
        n_checks++;
        if (excp_type_o !== 5'h04) begin
            n_fail++;
            $display("FAIL wrap_type: type=%h want 04", excp_type_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (redirect_pc_o !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL wrap_pc: pc=%h want 00000080", redirect_pc_o);
        end
        clear_inputs();
        finish_redirect("wrap");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        slot1_valid_i = 1; slot1_excp_i = 9'h004; ebase_i = 32'h0;
        #1;
        n_checks++;
        if (excp_flag_o !== 1 || excp_type_o !== 5'h0c) begin
            n_fail++;
            $display("FAIL ov_commit: flag=%0b type=%h want 1 0c", excp_flag_o, excp_type_o);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (redirect_valid_o !== 1 || redirect_pc_o !== 32'h180 || flush_o !== 1
                || excp_flag_o !== 0 || busy_o !== 1) begin
                n_fail++;
                $display("FAIL hold_%0d: valid=%0b pc=%h flush=%0b flag=%0b busy=%0b want 1 180 1 0 1",
                         i, redirect_valid_o, redirect_pc_o, flush_o, excp_flag_o, busy_o);
            end
            @(posedge clk); #1;
        end
        redirect_ready_i = 1;
        #1;
        n_checks++;
        if (redirect_valid_o !== 1 || excp_flag_o !== 0) begin
            n_fail++;
            $display("FAIL handshake: valid=%0b flag=%0b want 1 0", redirect_valid_o, excp_flag_o);
        end
        @(posedge clk); #1;
        redirect_ready_i = 0;
        n_checks++;
        if (redirect_valid_o !== 0 || busy_o !== 0 || excp_flag_o !== 1) begin
            n_fail++;
            $display("FAIL next_commit: valid=%0b busy=%0b flag=%0b want 0 0 1",
                     redirect_valid_o, busy_o, excp_flag_o);
        end
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_stall_and_reset();
        @(negedge clk);
        stall_i = 1; slot1_valid_i = 1; slot1_excp_i = 9'h020; ebase_i = 32'h1000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (excp_flag_o !== 0 || flush_o !== 0 || busy_o !== 0) begin
                n_fail++;
                $display("FAIL stall_%0d: flag=%0b flush=%0b busy=%0b want 0 0 0",
                         i, excp_flag_o, flush_o, busy_o);
            end
            @(negedge clk);
        end
        stall_i = 0;
        #1;
        n_checks++;
        if (excp_flag_o !== 1 || excp_type_o !== 5'h09) begin
            n_fail++;
            $display("FAIL unstall: flag=%0b type=%h want 1 09", excp_flag_o, excp_type_o);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy_o !== 1 || redirect_pc_o !== 32'h1000_0180) begin
            n_fail++;
            $display("FAIL stall_redirect: busy=%0b pc=%h want 1 10000180", busy_o, redirect_pc_o);
        end
        rst = 1;
        @(posedge clk); #1;
        n_checks++;
        if ({excp_flag_o, excp_type_o, excp_first_inst_o, flush_o, redirect_valid_o, busy_o} !== 10'b0
            || redirect_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_redirect: flag=%0b flush=%0b valid=%0b busy=%0b pc=%h want all 0",
                     excp_flag_o, flush_o, redirect_valid_o, busy_o, redirect_pc_o);
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ri_slot1();
        test_priority();
        test_interrupt();
        test_eret();
        test_wrap();
        test_back_to_back();
        test_stall_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $fatal(1, "timeout");
    end

endmodule
